// File: rtl/qif_spike_decoder.sv
// Spike decoder for the QIF neuron V stream: threshold detection with refractory
// re-arm, saturating inter-spike interval counter and a small ISI FIFO with valid/ready.
module qif_spike_decoder #(
  parameter int          V_PEAK     = 50,
  parameter int unsigned ISI_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       v_in,
  input  logic             v_valid,
  output logic             spike,
  output logic [15:0]      spike_count,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             overflow
);

  localparam int unsigned         AW        = $clog2(FIFO_DEPTH);
  localparam logic signed [7:0]   PEAK      = 8'(V_PEAK);
  localparam logic [ISI_W-1:0]    CNT_ONE   = 1;
  localparam logic [AW:0]         PTR_ONE   = 1;
  localparam logic [AW:0]         FULL_FILL = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]         SPK_ONE   = 1;

  typedef enum logic [1:0] {WAIT_FIRST, COUNT, REFRACT} state_t;

  state_t           state, next_state;
  logic [ISI_W-1:0] cnt, next_cnt, cnt_inc;
  logic             det, push;
  logic signed [7:0] v_s;
  logic             above;

  logic [ISI_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, fill;
  logic             full, pop, wr_en, drop;

  assign v_s     = v_in;
  assign above   = (v_s >= PEAK);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    det        = 1'b0;
    push       = 1'b0;
    if (v_valid) begin
      unique case (state)
        WAIT_FIRST: begin
          if (above) begin
            det        = 1'b1;
            next_cnt   = '0;
            next_state = REFRACT;
          end
        end
        COUNT: begin
          if (above) begin
            det        = 1'b1;
            push       = 1'b1;
            next_cnt   = '0;
            next_state = REFRACT;
          end else begin
            next_cnt = cnt_inc;
          end
        end
        REFRACT: begin
          next_cnt = cnt_inc;
          if (!above) next_state = COUNT;
        end
        default: next_state = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_FIRST;
      cnt         <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      spike <= det;
      if (det) spike_count <= spike_count + SPK_ONE;
    end
  end

  // A pop frees the slot the simultaneous push needs, so a full FIFO still accepts it.
  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == FULL_FILL);
  assign isi_valid = (wr_ptr != rd_ptr);
  assign pop       = isi_valid && isi_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign isi_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= cnt_inc;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Directed bench for qif_spike_decoder: default instance plus a 4-bit ISI instance
// for saturation; expected values are hand-derived from the sample sequences.
module tb_qif_spike_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  v_in = 8'hEC;
  logic        v_valid = 1'b0;
  logic        isi_ready = 1'b1;

  logic        spike, overflow, isi_valid;
  logic [15:0] spike_count, isi_data;
  logic        spike_s, overflow_s, isi_valid_s;
  logic [15:0] spike_count_s;
  logic [3:0]  isi_data_s;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  qif_spike_decoder #(.V_PEAK(50), .ISI_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .v_valid(v_valid),
    .spike(spike), .spike_count(spike_count), .isi_data(isi_data),
    .isi_valid(isi_valid), .isi_ready(isi_ready), .overflow(overflow)
  );

  qif_spike_decoder #(.V_PEAK(50), .ISI_W(4), .FIFO_DEPTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .v_valid(v_valid),
    .spike(spike_s), .spike_count(spike_count_s), .isi_data(isi_data_s),
    .isi_valid(isi_valid_s), .isi_ready(isi_ready), .overflow(overflow_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one sample, clock it, and check the registered spike pulse.
  task automatic step(input int v, input logic vld, input logic exp_spike);
    v_in    = 8'(v);
    v_valid = vld;
    @(posedge clk);
    #1;
    check("spike", 32'(spike), 32'(exp_spike));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset then idle
    #2;
    check("rst_spike", 32'(spike), 0);
    check("rst_count", 32'(spike_count), 0);
    check("rst_valid", 32'(isi_valid), 0);
    check("rst_data", 32'(isi_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(-20, 1'b1, 1'b0);
    check("idle_count", 32'(spike_count), 0);
    check("idle_valid", 32'(isi_valid), 0);

    // Basic ISI with isi_ready=1
    do_reset();
    isi_ready = 1'b1;
    step(-20, 1, 0);
    step(50, 1, 1);
    check("basic_first_nopush", 32'(isi_valid), 0);
    step(-20, 1, 0);
    step(-10, 1, 0);
    step(0, 1, 0);
    step(20, 1, 0);
    step(50, 1, 1);
    check("basic_valid", 32'(isi_valid), 1);
    check("basic_isi", 32'(isi_data), 5);
    step(-20, 1, 0);
    check("basic_popped", 32'(isi_valid), 0);
    check("basic_count", 32'(spike_count), 2);

    // Refractory / hysteresis
    do_reset();
    step(60, 1, 1);
    step(55, 1, 0);
    step(70, 1, 0);
    step(-20, 1, 0);
    step(51, 1, 1);
    check("refr_isi", 32'(isi_data), 4);
    check("refr_count", 32'(spike_count), 2);

    // Gapped valid: invalid cycles carry an above-threshold value that must be ignored
    do_reset();
    begin
      int seq [8] = '{-20, 50, -20, -10, 0, 20, 50, -20};
      for (int i = 0; i < 8; i++) begin
        step(seq[i], 1, (i == 1 || i == 6));
        if (i == 6) begin
          check("gap_valid", 32'(isi_valid), 1);
          check("gap_isi", 32'(isi_data), 5);
        end
        step(100, 0, 0);
      end
    end
    check("gap_count", 32'(spike_count), 2);

    // Full FIFO: six ISIs of 3 with no consumer
    do_reset();
    isi_ready = 1'b0;
    step(50, 1, 1);
    for (int k = 0; k < 6; k++) begin
      step(-20, 1, 0);
      step(-20, 1, 0);
      step(50, 1, 1);
      if (k == 3) check("full_no_ovf_yet", 32'(overflow), 0);
    end
    check("full_ovf", 32'(overflow), 1);
    v_valid   = 1'b0;
    isi_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(isi_valid), 1);
      check("drain_data", 32'(isi_data), 3);
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(isi_valid), 0);

    // Refill to full, then push ISI=4 in the same cycle as a pop
    isi_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(-20, 1, 0);
      step(-20, 1, 0);
      step(50, 1, 1);
    end
    step(-20, 1, 0);
    step(-20, 1, 0);
    step(-20, 1, 0);
    isi_ready = 1'b1;
    step(50, 1, 1);
    isi_ready = 1'b0;
    v_valid   = 1'b0;
    check("pp_count", 32'(spike_count), 12);
    isi_ready = 1'b1;
    begin
      int exp_q [4] = '{3, 3, 3, 4};
      for (int k = 0; k < 4; k++) begin
        check("pp_valid", 32'(isi_valid), 1);
        check("pp_data", 32'(isi_data), 32'(exp_q[k]));
        @(posedge clk); #1;
      end
    end
    check("pp_empty", 32'(isi_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Saturation: 20 samples between spikes
    do_reset();
    check("ovf_cleared", 32'(overflow), 0);
    step(50, 1, 1);
    for (int k = 0; k < 20; k++) step(-20, 1, 0);
    step(50, 1, 1);
    check("sat_valid", 32'(isi_valid_s), 1);
    check("sat_isi4", 32'(isi_data_s), 15);
    check("wide_isi16", 32'(isi_data), 21);

    // Reset mid-run with a non-empty FIFO
    do_reset();
    isi_ready = 1'b0;
    step(50, 1, 1);
    step(-20, 1, 0);
    step(50, 1, 1);
    check("mid_pre_valid", 32'(isi_valid), 1);
    check("mid_pre_isi", 32'(isi_data), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(isi_valid), 0);
    check("mid_rst_count", 32'(spike_count), 0);
    #1;
    rst_n = 1'b1;
    step(-20, 1, 0);
    step(50, 1, 1);
    check("mid_first_nopush", 32'(isi_valid), 0);
    step(-20, 1, 0);
    step(-20, 1, 0);
    step(50, 1, 1);
    check("mid_next_isi", 32'(isi_data), 3);
    check("mid_count", 32'(spike_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qif_spike_decoder.md
# qif_spike_decoder

Consumer-side decoder for the QIF neuron membrane-voltage stream. It samples the neuron's signed 8-bit V output, detects threshold crossings as spike events, and measures inter-spike intervals (ISI) in accepted samples. ISIs are buffered in a small FIFO and presented downstream over a valid/ready handshake. The block sits between the neuron core and the rate/readout logic, the read end of the neuron's V interface.

## Interface
- `V_PEAK`, default 50: signed spike threshold, same value the neuron uses.
- `ISI_W`, default 16: ISI counter and output width.
- `FIFO_DEPTH`, default 4: ISI buffer entries, power of two ≥ 2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `v_in`  in  8  neuron membrane voltage, two's-complement signed.
- `v_valid`  in  1  `v_in` is a new sample this cycle.
- `spike`  out  1  one-cycle pulse per detected spike.
- `spike_count`  out  16  total spikes detected since reset, wraps.
- `isi_data`  out  `ISI_W`  head-of-FIFO ISI value.
- `isi_valid`  out  1  FIFO non-empty.
- `isi_ready`  in  1  downstream accepts `isi_data`.
- `overflow`  out  1  sticky: an ISI was dropped because the FIFO was full.

## Operation
- Compare `v_in` against `V_PEAK` signed. For example, 8'hEC (-20) is below the threshold and 8'h80 is never a spike.
- All detection and counting advance only on cycles with `v_valid`=1. When `v_valid`=0, state and counters hold.
- FSM states:
  - WAIT_FIRST (reset state): on a sample ≥ `V_PEAK`, assert spike, clear the ISI counter to 0, and go to REFRACT. No ISI is pushed.
  - COUNT: each sample increments the ISI counter, which saturates at all-ones. On a sample ≥ `V_PEAK`, assert spike, push counter+1 (saturated) into the FIFO, clear the counter to 0, and go to REFRACT.
  - REFRACT: each sample increments the counter. A sample < `V_PEAK` re-arms the detector and moves to COUNT. A sample ≥ `V_PEAK` is not a new spike.
- ISI definition: the number of accepted samples after a spike sample up to and including the next spike sample. Spike samples at indices 0 and 5 give ISI = 5.
- `spike_count` increments on every detected spike and wraps from 16'hFFFF to 0.
- FIFO:
  - Push when a spike occurs in COUNT.
  - Pop when `isi_valid` && `isi_ready`.
  - Push when full and no pop in the same cycle: the value is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both succeed, no drop.
  - Push and pop in the same cycle when empty: the push is stored and the pop does nothing (`isi_valid` was 0).
- `overflow` clears only on reset.

## Timing
- Reset values: `spike`=0, `spike_count`=0, `isi_valid`=0, `isi_data`=0, `overflow`=0, state=WAIT_FIRST, ISI counter=0, FIFO empty.
- Reset is effective immediately when asserted. Reset mid-operation discards FIFO contents and the in-progress ISI.
- `spike` is registered: high the cycle after the edge that samples the crossing, for exactly one cycle.
- Push latency: if the FIFO is empty, `isi_valid` rises on the same cycle as `spike`.
- `isi_data` is driven from the FIFO head register or memory. It is stable while `isi_valid`=1 and `isi_ready`=0.
- After a pop, the next entry appears on the following cycle with no bubble. Sustained throughput is one ISI per cycle.
- `isi_valid` never depends combinationally on `isi_ready`.
- Back-to-back spikes are impossible: there is at least one below-threshold sample between detections.

## Test plan
- Reset then idle:
  - Stimulus: `rst_n`=0, then `v_in`=-20 for 10 valid samples.
  - Required: all outputs 0 and no spike.
- Basic ISI:
  - Stimulus: valid samples -20, 50, -20, -10, 0, 20, 50, -20, with `isi_ready`=1.
  - Required: `spike` pulses twice and `spike_count`=2.
  - Required: one ISI = 5, and the first spike pushes nothing.
- Refractory/hysteresis:
  - Stimulus: samples 60, 55, 70, -20, 51.
  - Required: exactly 2 spikes and ISI = 4.
- Gapped valid:
  - Stimulus: the basic-ISI sequence with `v_valid` low on alternate cycles.
  - Required: identical ISI = 5 and spike count.
- Full FIFO:
  - Stimulus: `isi_ready`=0 and 6 ISIs produced (e.g. ISI=3 each).
  - Required: 4 stored and `overflow`=1.
  - Required: on releasing `isi_ready`, exactly four 3's drain, one per cycle.
  - Simultaneous push and pop when full: no drop.
- Saturation and reset mid-run:
  - Stimulus: `ISI_W`=4 with 20 samples between spikes.
  - Required: ISI=15.
  - Stimulus: assert `rst_n` low while the FIFO is non-empty.
  - Required: `isi_valid`=0 at once, state WAIT_FIRST, and the next spike pushes nothing.
